// File: rtl/lab2_proc_ctrl_pkg.sv
// Shared decode types and RV32 opcodes for the lab2 processor dpath immediate generator and ctrl stages.
package lab2_proc_ctrl_pkg;

  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_U  = 3'd3,
    IMM_J  = 3'd4,
    IMM_IS = 3'd5
  } imm_type_t;

  typedef enum logic [1:0] {
    BYP_RF = 2'd0,
    BYP_X  = 2'd1,
    BYP_M  = 2'd2,
    BYP_W  = 2'd3
  } byp_sel_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // x0 is hardwired, so it never aliases a pending write.
  function automatic logic reg_match(input logic wen, input logic [4:0] waddr, input logic [4:0] r);
    return wen & (waddr == r) & (r != 5'd0);
  endfunction

endpackage

// File: rtl/lab2_proc_ctrl_hazard.sv
// D-stage source/destination compare producing hazard_D and operand bypass selects.
// Build option LAB2_PROC_BYPASS_EN: bypass from X/M/W, stall only on load-use.
module lab2_proc_ctrl_hazard
  import lab2_proc_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rf_waddr_X,
  input  logic [4:0] rf_waddr_M,
  input  logic [4:0] rf_waddr_W,
  input  logic       rf_wen_X,
  input  logic       rf_wen_M,
  input  logic       rf_wen_W,
  input  logic       is_load_X,
  output logic       hazard,
  output byp_sel_t   op1_byp_sel,
  output byp_sel_t   op2_byp_sel
);
  logic rs1_x, rs1_m, rs1_w, rs2_x, rs2_m, rs2_w;

  assign rs1_x = rs1_used & reg_match(rf_wen_X, rf_waddr_X, rs1);
  assign rs1_m = rs1_used & reg_match(rf_wen_M, rf_waddr_M, rs1);
  assign rs1_w = rs1_used & reg_match(rf_wen_W, rf_waddr_W, rs1);
  assign rs2_x = rs2_used & reg_match(rf_wen_X, rf_waddr_X, rs2);
  assign rs2_m = rs2_used & reg_match(rf_wen_M, rf_waddr_M, rs2);
  assign rs2_w = rs2_used & reg_match(rf_wen_W, rf_waddr_W, rs2);

`ifdef LAB2_PROC_BYPASS_EN
  // Load data is not available until M, so only a load in X forces a stall.
  assign hazard = is_load_X & (rs1_x | rs2_x);

  always_comb begin
    op1_byp_sel = BYP_RF;
    if (rs1_x)      op1_byp_sel = BYP_X;
    else if (rs1_m) op1_byp_sel = BYP_M;
    else if (rs1_w) op1_byp_sel = BYP_W;
    op2_byp_sel = BYP_RF;
    if (rs2_x)      op2_byp_sel = BYP_X;
    else if (rs2_m) op2_byp_sel = BYP_M;
    else if (rs2_w) op2_byp_sel = BYP_W;
  end
`else
  logic unused_load;

  assign unused_load = is_load_X;
  assign hazard      = rs1_x | rs1_m | rs1_w | rs2_x | rs2_m | rs2_w;
  assign op1_byp_sel = BYP_RF;
  assign op2_byp_sel = BYP_RF;
`endif

endmodule

// File: rtl/lab2_proc_ctrl_dstage.sv
// Decode-stage controller: D valid bit, instruction decode, stall/squash/bypass control, stall counter.
// Build option LAB2_PROC_BYPASS_EN selects bypassing in lab2_proc_ctrl_hazard.
module lab2_proc_ctrl_dstage
  import lab2_proc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             val_FD,
  input  logic [31:0]      inst_D,
  input  logic             squash_D,
  input  logic             ostall_X,
  input  logic [4:0]       rf_waddr_X,
  input  logic [4:0]       rf_waddr_M,
  input  logic [4:0]       rf_waddr_W,
  input  logic             rf_wen_X,
  input  logic             rf_wen_M,
  input  logic             rf_wen_W,
  input  logic             is_load_X,
  output logic             reg_en_D,
  output logic             ostall_D,
  output logic             val_DX,
  output logic [2:0]       imm_type_D,
  output logic             op2_sel_D,
  output logic [1:0]       op1_byp_sel_D,
  output logic [1:0]       op2_byp_sel_D,
  output logic             illegal_D,
  output logic [CNT_W-1:0] stall_cnt
);
  logic             val_D_q, val_D_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             legal, rs1_used, rs2_used, op2_sel;
  logic             hazard_D, stall_D;
  imm_type_t        imm_type;
  byp_sel_t         op1_byp, op2_byp;
  logic             unused_inst;

  assign opcode      = inst_D[6:0];
  assign funct3      = inst_D[14:12];
  assign unused_inst = ^{inst_D[31:25], inst_D[11:7]};

  always_comb begin
    imm_type = IMM_I;
    op2_sel  = 1'b1;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OPC_OP:     begin op2_sel = 1'b0; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_OPIMM:  begin
                    rs1_used = 1'b1;
                    if (funct3 == 3'b001 || funct3 == 3'b101) imm_type = IMM_IS;
                  end
      OPC_LOAD,
      OPC_JALR:   rs1_used = 1'b1;
      OPC_STORE:  begin imm_type = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_BRANCH: begin imm_type = IMM_B; op2_sel = 1'b0; rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_LUI,
      OPC_AUIPC:  imm_type = IMM_U;
      OPC_JAL:    imm_type = IMM_J;
      default:    legal = 1'b0;
    endcase
  end

  // Gating the source flags with val_D keeps the bypass selects at RF while D is empty.
  lab2_proc_ctrl_hazard u_hazard (
    .rs1         (inst_D[19:15]),
    .rs2         (inst_D[24:20]),
    .rs1_used    (val_D_q & rs1_used),
    .rs2_used    (val_D_q & rs2_used),
    .rf_waddr_X  (rf_waddr_X),
    .rf_waddr_M  (rf_waddr_M),
    .rf_waddr_W  (rf_waddr_W),
    .rf_wen_X    (rf_wen_X),
    .rf_wen_M    (rf_wen_M),
    .rf_wen_W    (rf_wen_W),
    .is_load_X   (is_load_X),
    .hazard      (hazard_D),
    .op1_byp_sel (op1_byp),
    .op2_byp_sel (op2_byp)
  );

  assign stall_D       = val_D_q & (hazard_D | ostall_X);
  assign ostall_D      = stall_D;
  assign reg_en_D      = ~stall_D | squash_D;
  assign illegal_D     = val_D_q & ~legal;
  assign val_DX        = val_D_q & ~stall_D & ~squash_D & ~illegal_D;
  assign imm_type_D    = imm_type;
  assign op2_sel_D     = op2_sel;
  assign op1_byp_sel_D = op1_byp;
  assign op2_byp_sel_D = op2_byp;
  assign stall_cnt     = stall_cnt_q;

  always_comb begin
    val_D_d     = reg_en_D ? val_FD : val_D_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_D);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_D_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      val_D_q     <= val_D_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
